spi_bus_arbiter: RTL
====================

SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001: The block SHALL have parameter CS_GAP, default 32, meaning the minimum number of cycles all chip selects stay high between transactions (range 1..255).
REQ-002: The block SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning the number of idle cycles in a grant before forced release (range 2..65535).
REQ-003: Port clk  input  1  system clock (28 MHz); all logic on rising edge.
REQ-004: Port rst  input  1  reset, synchronous, active-high.
REQ-005: Port req  input  2  per-requester bus request; bit i belongs to requester i; held high for the whole transaction.
REQ-006: Port gnt  output  2  one-hot-or-zero grant.
REQ-007: Port tx_byte0, tx_byte1  input  8 each  byte to send, per requester.
REQ-008: Port tx_dv  input  2  per-requester one-cycle byte-valid pulse.
REQ-009: Port tx_ready  output  2  per-requester ready-for-next-byte.
REQ-010: Port rx_dv  output  2  per-requester one-cycle received-byte pulse.
REQ-011: Port rx_byte  output  8  last received byte, shared.
REQ-012: Port cs_n  output  2  per-device chip select, active low.
REQ-013: Port m_tx_byte, m_tx_dv, m_tx_ready, m_rx_dv, m_rx_byte  out 8 / out 1 / in 1 / in 1 / in 8  byte-level SPI master side.
REQ-014: Port timeout  output  2  per-requester one-cycle forced-release pulse.

Function
REQ-015: The controller SHALL use the states IDLE, SETUP, GRANT, DRAIN and GAP.
REQ-016: In IDLE, when any req bit is high, the controller SHALL pick a winner w, drive cs_n[w] low on the next cycle, and go to SETUP.
REQ-017: When both req bits are high in IDLE, the controller SHALL grant the requester that is not last_served (round-robin).
REQ-018: SETUP SHALL last exactly 1 cycle, then the controller SHALL go to GRANT with gnt[w]=1.
REQ-019: In GRANT, m_tx_byte/m_tx_dv SHALL equal the winner's tx_byte/tx_dv combinationally, gated by m_tx_ready; tx_dv while m_tx_ready=0 is dropped.
REQ-020: In GRANT, tx_ready[w] SHALL equal m_tx_ready, and tx_ready of the non-granted requester SHALL be 0.
REQ-021: rx_dv[w] SHALL equal m_rx_dv only in GRANT/DRAIN, rx_byte SHALL equal m_rx_byte, and the non-granted rx_dv SHALL be 0.
REQ-022: The non-granted requester's tx_dv SHALL never reach m_tx_dv.
REQ-023: In GRANT, when req[w] falls, gnt SHALL drop the same cycle and the controller SHALL go to DRAIN.
REQ-024: In DRAIN, the controller SHALL hold cs_n[w] low until m_tx_ready=1, then raise cs_n[w], record last_served=w, and go to GAP.
REQ-025: GAP SHALL hold all cs_n high for CS_GAP cycles (8-bit counter), then the controller SHALL go to IDLE; requests arriving during GAP wait.
REQ-026: At most one cs_n bit SHALL be low at any time, and cs_n SHALL be registered.
REQ-027: A requester that re-raises req during DRAIN/GAP while the other requester is requesting SHALL lose the next arbitration.

Reset
REQ-028: With rst high at a clock edge, on the next cycle the block SHALL go to state IDLE with cs_n=2'b11, gnt=0, tx_ready=0, rx_dv=0, m_tx_dv=0, timeout=0, GAP counter=0, and last_served=1 (requester 0 wins first).
REQ-029: Reset mid-transaction SHALL abort immediately, with no DRAIN and no GAP.

Configuration
REQ-030: With macro SPI_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entry to GRANT and on each forwarded m_tx_dv or m_rx_dv, and SHALL increment otherwise in GRANT.
REQ-031: With SPI_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES, the block SHALL drop gnt[w], pulse timeout[w] for 1 cycle, and go to DRAIN regardless of req[w].
REQ-032: After a timeout, the block SHALL treat req[w] as low until req[w] is seen low for one cycle.
REQ-033: Without SPI_ARB_TIMEOUT_EN, no counter SHALL exist, timeout SHALL be constant 2'b00, and a grant SHALL last until req[w] falls.

Verification
REQ-034: Stimulus: after reset, req=2'b11 held. Required: cs_n=2'b10 at cycle +1, gnt=2'b01 at +2; after req[0] drops and 32 gap cycles, cs_n=2'b01 and gnt=2'b10.
REQ-035: Stimulus: requester 0 sends 0x40,0x12,0x00 with m_tx_ready modelled as low for 48 cycles per byte. Required: m_tx_byte sequence 0x40,0x12,0x00, and rx_dv[0] pulses 3 times with rx_byte=m_rx_byte.
REQ-036: Stimulus: requester 1 pulses tx_dv=1 with tx_byte1=0xAA while requester 0 is granted. Required: m_tx_dv stays 0 and tx_ready[1]=0.
REQ-037: Stimulus: req[0] drops while m_tx_ready=0. Required: cs_n[0] stays low until m_tx_ready rises, then goes high for ≥32 cycles.
REQ-038: Stimulus: rst asserted in GRANT mid-byte. Required: the next cycle shows cs_n=2'b11, gnt=0, m_tx_dv=0; after release with req=2'b11, requester 0 is granted.
REQ-039: Stimulus: SPI_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, requester 1 granted and silent. Required: timeout=2'b10 pulse at 100 cycles, cs_n[1] high after drain, no re-grant until req[1] toggles.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Two-requester arbiter sharing one byte-level SPI master, with round-robin grant and per-device chip selects.
// Optional idle-grant forced release is built when SPI_ARB_TIMEOUT_EN is defined.
module spi_bus_arbiter #(
  parameter int CS_GAP         = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic [7:0] tx_byte0,
  input  logic [7:0] tx_byte1,
  input  logic [1:0] tx_dv,
  output logic [1:0] tx_ready,
  output logic [1:0] rx_dv,
  output logic [7:0] rx_byte,
  output logic [1:0] cs_n,
  output logic [7:0] m_tx_byte,
  output logic       m_tx_dv,
  input  logic       m_tx_ready,
  input  logic       m_rx_dv,
  input  logic [7:0] m_rx_byte,
  output logic [1:0] timeout
);

  // state | meaning
  // IDLE  | all cs_n high, arbitrate on any request
  // SETUP | winner's cs_n low, one cycle before grant
  // GRANT | winner owns the master
  // DRAIN | grant gone, wait for master to finish the byte
  // GAP   | all cs_n high for CS_GAP cycles
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_GRANT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  if (CS_GAP < 1 || CS_GAP > 255) begin : g_bad_cs_gap
    $error("CS_GAP must be in 1..255");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end

  logic [2:0] state_q, state_d;
  logic       win_q, win_d;
  logic       last_q, last_d;
  logic [1:0] cs_n_q, cs_n_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;

  logic [1:0] req_eff;
  logic [1:0] win_oh;
  logic       in_grant, in_xfer, own_req, gnt_on, tmo_hit;

  assign in_grant = (state_q == S_GRANT);
  assign in_xfer  = in_grant || (state_q == S_DRAIN);
  assign win_oh   = win_q ? 2'b10 : 2'b01;
  assign own_req  = req_eff[win_q];

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  // A timed-out requester is masked until it has been seen deasserted once.
  logic [1:0]  tmo_blk_q, tmo_blk_d;

  assign req_eff = req & ~tmo_blk_q;
  assign tmo_hit = in_grant && own_req && (tmo_cnt_q == TMO_LIMIT);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_blk_d = (tmo_blk_q & req) | (tmo_hit ? win_oh : 2'b00);
    if (state_q == S_SETUP) begin
      tmo_cnt_d = 16'd0;
    end else if (in_grant) begin
      tmo_cnt_d = (m_tx_dv || (rx_dv != 2'b00)) ? 16'd0 : tmo_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= 16'd0;
      tmo_blk_q <= 2'b00;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_blk_q <= tmo_blk_d;
    end
  end
`else
  assign req_eff = req;
  assign tmo_hit = 1'b0;
`endif

  assign gnt_on    = in_grant && own_req && !tmo_hit;
  assign gnt       = gnt_on ? win_oh : 2'b00;
  assign m_tx_byte = gnt_on ? (win_q ? tx_byte1 : tx_byte0) : 8'h00;
  assign m_tx_dv   = gnt_on && tx_dv[win_q] && m_tx_ready;
  assign tx_ready  = (gnt_on && m_tx_ready) ? win_oh : 2'b00;
  assign rx_dv     = (in_xfer && m_rx_dv) ? win_oh : 2'b00;
  assign rx_byte   = m_rx_byte;
  assign cs_n      = cs_n_q;
  assign timeout   = tmo_hit ? win_oh : 2'b00;

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    last_d    = last_q;
    cs_n_d    = cs_n_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_eff != 2'b00) begin
          win_d   = (req_eff == 2'b11) ? ~last_q : req_eff[1];
          cs_n_d  = win_d ? 2'b01 : 2'b10;
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_GRANT;
      S_GRANT: begin
        if (!own_req || tmo_hit) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (m_tx_ready) begin
          cs_n_d    = 2'b11;
          last_d    = win_q;
          gap_cnt_d = 8'd0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q + 8'd1;
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = 2'b11;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      win_q     <= 1'b0;
      last_q    <= 1'b1;
      cs_n_q    <= 2'b11;
      gap_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      cs_n_q    <= cs_n_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

endmodule
